// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// accumulator shift-select codes and the control-bundle layout.
package instr_sequencer_pkg;

   // Default number of MUL/DIV iteration cycles (accumulator half-width)
   localparam int N_ITER_DEFAULT = 4;

   // Opcodes, ir[7:4]
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_LDB = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_MUL = 4'h6;
   localparam logic [3:0] OP_DIV = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_OUT = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_JZ  = 4'hC;
   localparam logic [3:0] OP_JN  = 4'hD;
   localparam logic [3:0] OP_CLR = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Accumulator high/low shift select codes
   localparam logic [1:0] SH_HOLD  = 2'b00;
   localparam logic [1:0] SH_RIGHT = 2'b01;
   localparam logic [1:0] SH_LEFT  = 2'b10;
   localparam logic [1:0] SH_LOAD  = 2'b11;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_ITER   = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // All datapath controls driven by the sequencer in one bundle
   typedef struct packed {
      logic       mem_oen;
      logic       ah_reset;
      logic       ah_inen;
      logic       s_add;
      logic       s_sub;
      logic       s_and;
      logic       s_mul;
      logic       s_div;
      logic       clr;
      logic       acc_oen;
      logic       breg_ld;
      logic [1:0] hs;
      logic [1:0] ls;
      logic       halt;
   } ctrl_t;

   // MUL and DIV are the only opcodes that spend extra cycles in ITER
   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational decode of (FSM state, opcode) into datapath controls.
// Every control not explicitly asserted for a state/opcode stays 0, so at
// most one ALU operation select is ever high.
module seq_decode
   import instr_sequencer_pkg::*;
(
   input  state_e     state_i,
   input  logic [3:0] opcode_i,
   output ctrl_t      ctrl_o
);

   // Control decode: defaults first, then per-state assertions
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_IDLE: begin
            ctrl_o.ah_reset = 1'b1;
         end
         ST_FETCH: begin
            ctrl_o.mem_oen = 1'b1;
         end
         ST_DECODE: begin
            // deliberately quiet: IR has just been loaded
         end
         ST_EXEC: begin
            case (opcode_i)
               OP_LDA: begin
                  ctrl_o.ah_inen = 1'b1;
                  ctrl_o.hs      = SH_LOAD;
               end
               OP_LDB: ctrl_o.breg_ld = 1'b1;
               OP_ADD: begin
                  ctrl_o.s_add = 1'b1;
                  ctrl_o.hs    = SH_LOAD;
               end
               OP_SUB: begin
                  ctrl_o.s_sub = 1'b1;
                  ctrl_o.hs    = SH_LOAD;
               end
               OP_AND: begin
                  ctrl_o.s_and = 1'b1;
                  ctrl_o.hs    = SH_LOAD;
               end
               OP_MUL: begin
                  ctrl_o.s_mul = 1'b1;
                  ctrl_o.hs    = SH_LOAD;
               end
               OP_DIV: begin
                  ctrl_o.s_div = 1'b1;
                  ctrl_o.hs    = SH_LOAD;
               end
               OP_SHL: begin
                  ctrl_o.hs = SH_LEFT;
                  ctrl_o.ls = SH_LEFT;
               end
               OP_SHR: begin
                  ctrl_o.hs = SH_RIGHT;
                  ctrl_o.ls = SH_RIGHT;
               end
               OP_OUT: ctrl_o.acc_oen = 1'b1;
               OP_CLR: ctrl_o.clr     = 1'b1;
               default: begin
                  // NOP, jumps and HLT drive no datapath controls
               end
            endcase
         end
         ST_ITER: begin
            // hs is left at hold; the datapath overrides it during iteration
            ctrl_o.s_mul = (opcode_i == OP_MUL);
            ctrl_o.s_div = (opcode_i == OP_DIV);
            ctrl_o.ls    = SH_RIGHT;
         end
         ST_HALT: begin
            ctrl_o.halt = 1'b1;
         end
         default: begin
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC per instruction, with N_ITER
// extra ITER cycles for MUL/DIV. Holds the FSM, program counter, IR and
// iteration counter; controls are decoded combinationally from registered
// state and IR, so an asynchronous reset silences them immediately.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int N_ITER = N_ITER_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] ir_in,
   input  logic       sign_flag,
   input  logic       zero_flag,
   output logic [3:0] pc_out,
   output logic       mem_oen,
   output logic       ah_reset,
   output logic       ah_inen,
   output logic       s_add,
   output logic       s_sub,
   output logic       s_and,
   output logic       s_mul,
   output logic       s_div,
   output logic       clr,
   output logic       acc_oen,
   output logic       breg_ld,
   output logic [1:0] hs,
   output logic [1:0] ls,
   output logic       halt,
   output state_e     dbg_state
);

   localparam int CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

   state_e           state_q, state_d;
   logic [3:0]       pc_q, pc_d;
   logic [7:0]       ir_q, ir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             take_jump;
   ctrl_t            ctrl;

   // Branch condition for the instruction in IR; flags are only consulted in EXEC
   always_comb begin
      take_jump = 1'b0;
      case (ir_q[7:4])
         OP_JMP:  take_jump = 1'b1;
         OP_JZ:   take_jump = zero_flag;
         OP_JN:   take_jump = sign_flag;
         default: take_jump = 1'b0;
      endcase
   end

   // Next-state logic for FSM, pc, IR and iteration counter
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_d    = ir_in;
            pc_d    = pc_q + 4'd1;   // wraps 15 -> 0
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (take_jump) pc_d = ir_q[3:0];
            if (ir_q[7:4] == OP_HLT) begin
               state_d = ST_HALT;
            end else if (is_iterative(ir_q[7:4])) begin
               cnt_d   = '0;
               state_d = ST_ITER;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_ITER: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HALT: begin
            // only reset leaves HALT
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   seq_decode u_decode (
      .state_i  (state_q),
      .opcode_i (ir_q[7:4]),
      .ctrl_o   (ctrl)
   );

   assign pc_out    = pc_q;
   assign mem_oen   = ctrl.mem_oen;
   assign ah_reset  = ctrl.ah_reset;
   assign ah_inen   = ctrl.ah_inen;
   assign s_add     = ctrl.s_add;
   assign s_sub     = ctrl.s_sub;
   assign s_and     = ctrl.s_and;
   assign s_mul     = ctrl.s_mul;
   assign s_div     = ctrl.s_div;
   assign clr       = ctrl.clr;
   assign acc_oen   = ctrl.acc_oen;
   assign breg_ld   = ctrl.breg_ld;
   assign hs        = ctrl.hs;
   assign ls        = ctrl.ls;
   assign halt      = ctrl.halt;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a per-opcode vector table plus hand-written
// sequences for the program example, MUL iteration, pc wrap, reset abort
// and HALT behaviour. Program memory is a small array addressed by pc_out.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  // Flattened control view: {mem_oen, ah_reset, ah_inen, s_add, s_sub, s_and,
  //   s_mul, s_div, clr, acc_oen, breg_ld, hs[1:0], ls[1:0], halt}
  localparam logic [15:0] C_MEM  = 16'h8000;
  localparam logic [15:0] C_AHR  = 16'h4000;
  localparam logic [15:0] C_INEN = 16'h2000;
  localparam logic [15:0] C_ADD  = 16'h1000;
  localparam logic [15:0] C_SUB  = 16'h0800;
  localparam logic [15:0] C_AND  = 16'h0400;
  localparam logic [15:0] C_MUL  = 16'h0200;
  localparam logic [15:0] C_DIV  = 16'h0100;
  localparam logic [15:0] C_CLR  = 16'h0080;
  localparam logic [15:0] C_OEN  = 16'h0040;
  localparam logic [15:0] C_BLD  = 16'h0020;
  localparam logic [15:0] HS_LD  = 16'h0018;
  localparam logic [15:0] HS_L   = 16'h0010;
  localparam logic [15:0] HS_R   = 16'h0008;
  localparam logic [15:0] LS_L   = 16'h0004;
  localparam logic [15:0] LS_R   = 16'h0002;
  localparam logic [15:0] C_HALT = 16'h0001;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] ir_in;
  logic       sign_flag;
  logic       zero_flag;
  logic [3:0] pc_out;
  logic       mem_oen, ah_reset, ah_inen, s_add, s_sub, s_and, s_mul, s_div;
  logic       clr, acc_oen, breg_ld, halt;
  logic [1:0] hs, ls;
  state_e     dbg_state;
  logic [15:0] ctl;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  ir;
    logic        zf;
    logic        sf;
    logic [15:0] exp_ctl;
    logic [3:0]  exp_pc;
  } vec_t;

  vec_t vecs [15];

  instr_sequencer #(.N_ITER(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ir_in     (ir_in),
    .sign_flag (sign_flag),
    .zero_flag (zero_flag),
    .pc_out    (pc_out),
    .mem_oen   (mem_oen),
    .ah_reset  (ah_reset),
    .ah_inen   (ah_inen),
    .s_add     (s_add),
    .s_sub     (s_sub),
    .s_and     (s_and),
    .s_mul     (s_mul),
    .s_div     (s_div),
    .clr       (clr),
    .acc_oen   (acc_oen),
    .breg_ld   (breg_ld),
    .hs        (hs),
    .ls        (ls),
    .halt      (halt),
    .dbg_state (dbg_state)
  );

  assign ir_in = mem[pc_out];
  assign ctl = {mem_oen, ah_reset, ah_inen, s_add, s_sub, s_and, s_mul, s_div,
                clr, acc_oen, breg_ld, hs, ls, halt};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Asynchronous reset: outputs must change without waiting for a clock
  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_AHR));
    chk("reset_pc", 32'(pc_out), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Pulse start; returns sampled in cycle 1 (first FETCH)
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [15:0] exp_prog(input int c);
    if (c >= 16)     return C_HALT;
    if (c == 3)      return C_INEN | HS_LD;
    if (c == 6)      return C_BLD;
    if (c == 9)      return C_ADD | HS_LD;
    if (c == 12)     return C_OEN;
    if (c % 3 == 1)  return C_MEM;
    return 16'h0000;
  endfunction

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 1'b0, 16'h0000,        4'd1};
    vecs[1]  = '{8'h13, 1'b0, 1'b0, C_INEN | HS_LD,  4'd1};
    vecs[2]  = '{8'h25, 1'b0, 1'b0, C_BLD,           4'd1};
    vecs[3]  = '{8'h30, 1'b0, 1'b0, C_ADD | HS_LD,   4'd1};
    vecs[4]  = '{8'h40, 1'b0, 1'b0, C_SUB | HS_LD,   4'd1};
    vecs[5]  = '{8'h50, 1'b0, 1'b0, C_AND | HS_LD,   4'd1};
    vecs[6]  = '{8'h80, 1'b0, 1'b0, HS_L | LS_L,     4'd1};
    vecs[7]  = '{8'h90, 1'b0, 1'b0, HS_R | LS_R,     4'd1};
    vecs[8]  = '{8'hA0, 1'b0, 1'b0, C_OEN,           4'd1};
    vecs[9]  = '{8'hB7, 1'b0, 1'b0, 16'h0000,        4'd7};
    vecs[10] = '{8'hC9, 1'b1, 1'b0, 16'h0000,        4'd9};
    vecs[11] = '{8'hC9, 1'b0, 1'b1, 16'h0000,        4'd1};
    vecs[12] = '{8'hD4, 1'b0, 1'b1, 16'h0000,        4'd4};
    vecs[13] = '{8'hD4, 1'b1, 1'b0, 16'h0000,        4'd1};
    vecs[14] = '{8'hE0, 1'b0, 1'b0, C_CLR,           4'd1};

    rst_n = 1'b0;
    start = 1'b0;
    sign_flag = 1'b0;
    zero_flag = 1'b0;
    clear_mem();
    #2;

    // Table: one instruction at address 0 from a fresh reset
    for (int v = 0; v < 15; v++) begin
      clear_mem();
      mem[0] = vecs[v].ir;
      sign_flag = 1'b0;
      zero_flag = 1'b0;
      do_reset();
      start_run();
      chk($sformatf("v%0d_fetch_ctl", v), 32'(ctl), 32'(C_MEM));
      chk($sformatf("v%0d_fetch_pc", v), 32'(pc_out), 32'd0);
      tick();
      sign_flag = vecs[v].sf;
      zero_flag = vecs[v].zf;
      chk($sformatf("v%0d_decode_ctl", v), 32'(ctl), 32'd0);
      tick();
      chk($sformatf("v%0d_exec_ctl", v), 32'(ctl), 32'(vecs[v].exp_ctl));
      tick();
      sign_flag = 1'b0;
      zero_flag = 1'b0;
      chk($sformatf("v%0d_next_ctl", v), 32'(ctl), 32'(C_MEM));
      chk($sformatf("v%0d_next_pc", v), 32'(pc_out), 32'(vecs[v].exp_pc));
    end

    // Program LDA 3, LDB 5, ADD, OUT, HLT; cycle 1 is the first FETCH
    clear_mem();
    mem[0] = 8'h13; mem[1] = 8'h25; mem[2] = 8'h30; mem[3] = 8'hA0; mem[4] = 8'hF0;
    do_reset();
    start_run();
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("prog_c%0d_ctl", c), 32'(ctl), 32'(exp_prog(c)));
      if (c < 20) tick();
    end
    chk("prog_halt_pc", 32'(pc_out), 32'd5);

    // MUL: EXEC plus four ITER cycles, then FETCH at pc 1
    begin
      int mul_cnt;
      logic [15:0] exp_m;
      clear_mem();
      mem[0] = 8'h60;
      do_reset();
      start_run();
      mul_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
        if (c == 1 || c == 8) exp_m = C_MEM;
        else if (c == 2)      exp_m = 16'h0000;
        else if (c == 3)      exp_m = C_MUL | HS_LD;
        else                  exp_m = C_MUL | LS_R;
        chk($sformatf("mul_c%0d_ctl", c), 32'(ctl), 32'(exp_m));
        if (s_mul) mul_cnt++;
        if (c < 8) tick();
      end
      chk("mul_pulse_count", 32'(mul_cnt), 32'd5);
      chk("mul_next_pc", 32'(pc_out), 32'd1);
    end

    // 16 NOPs: pc walks 0..15 and wraps to 0
    clear_mem();
    do_reset();
    start_run();
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("nop_pc_%0d", i), 32'(pc_out), 32'(i % 16));
      chk($sformatf("nop_fetch_%0d", i), 32'(ctl), 32'(C_MEM));
      if (i < 16) begin
        tick(); tick(); tick();
      end
    end

    // Reset during the 2nd ITER cycle of DIV aborts immediately
    clear_mem();
    mem[0] = 8'h70;
    do_reset();
    start_run();
    tick(); tick(); tick(); tick();   // cycle 5: second ITER
    chk("div_iter2_ctl", 32'(ctl), 32'(C_DIV | LS_R));
    rst_n = 1'b0;
    #1;
    chk("div_abort_ctl", 32'(ctl), 32'(C_AHR));
    chk("div_abort_pc", 32'(pc_out), 32'd0);
    chk("div_abort_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("div_idle_%0d", i), 32'(ctl), 32'(C_AHR));
    end
    start_run();
    chk("div_restart_ctl", 32'(ctl), 32'(C_MEM));
    chk("div_restart_pc", 32'(pc_out), 32'd0);

    // HALT ignores start
    clear_mem();
    mem[0] = 8'hF0;
    do_reset();
    start_run();
    tick(); tick(); tick();           // cycle 4: HALT
    chk("halt_entry_ctl", 32'(ctl), 32'(C_HALT));
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("halt_hold_ctl_%0d", i), 32'(ctl), 32'(C_HALT));
      chk($sformatf("halt_hold_pc_%0d", i), 32'(pc_out), 32'd1);
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
